// File: rtl/cpu_result_logger.sv
// Result log for the CPU writeback path: stores up to DEPTH words and replays them
// one per step request as clamped 4-digit packed BCD via a sequential double-dabble.
module cpu_result_logger #(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              log_clear,
    input  logic              rd_next,
    output logic [15:0]       rd_bcd,
    output logic [4:0]        rd_index,
    output logic              rd_sat,
    output logic              bcd_valid,
    output logic              busy,
    output logic [5:0]        count,
    output logic              full,
    output logic              overflow
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int BIN_W   = 14;
    localparam int BCD_MAX = 9999;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t              state;
    state_t              next_state;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   entry;
    logic                wr_en;
    logic                accept;

    logic [PTR_W-1:0]    rp;
    logic [PTR_W-1:0]    sel_idx;
    logic [5:0]          rp_inc;

    logic [BIN_W-1:0]    bin;
    logic [15:0]         bcd;
    logic [15:0]         bcd_adj;
    logic                sat_q;
    logic [3:0]          shift_cnt;

    assign full     = (count == 6'(DEPTH));
    assign wr_ready = !full;
    assign busy     = (state != IDLE);
    assign accept   = (state == IDLE) && rd_next && (count != 6'd0);
    assign rp_inc   = 6'(rp) + 6'd1;
    assign entry    = mem[sel_idx];

    // A clear or reset in the same cycle discards the incoming word.
    assign wr_en = wr_valid && !full && !log_clear && !reset;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[count[PTR_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= 6'd0;
            overflow <= 1'b0;
        end else if (log_clear) begin
            count    <= 6'd0;
            overflow <= 1'b0;
        end else if (wr_valid) begin
            if (!full) begin
                count <= count + 6'd1;
            end else begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = LOAD;
            LOAD:    next_state = SHIFT;
            SHIFT:   if (shift_cnt == 4'd1) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (log_clear) begin
            next_state = IDLE;
        end
    end

    // Double-dabble correction applied before every left shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rp        <= '0;
            sel_idx   <= '0;
            bin       <= '0;
            bcd       <= '0;
            sat_q     <= 1'b0;
            shift_cnt <= 4'd0;
            rd_bcd    <= 16'd0;
            rd_index  <= 5'd0;
            rd_sat    <= 1'b0;
            bcd_valid <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            if (log_clear) begin
                rp <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            sel_idx <= rp;
                            rp      <= (rp_inc >= count) ? '0 : rp_inc[PTR_W-1:0];
                        end
                    end
                    LOAD: begin
                        if (entry > DATA_W'(BCD_MAX)) begin
                            bin   <= BIN_W'(BCD_MAX);
                            sat_q <= 1'b1;
                        end else begin
                            bin   <= entry[BIN_W-1:0];
                            sat_q <= 1'b0;
                        end
                        bcd       <= 16'd0;
                        shift_cnt <= 4'd14;
                    end
                    SHIFT: begin
                        {bcd, bin} <= {bcd_adj, bin} << 1;
                        shift_cnt  <= shift_cnt - 4'd1;
                    end
                    DONE: begin
                        rd_bcd    <= bcd;
                        rd_index  <= 5'(sel_idx);
                        rd_sat    <= sat_q;
                        bcd_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu_result_logger.sv
// Self-checking bench for cpu_result_logger: directed vectors, corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_cpu_result_logger;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = 32'd0;
    logic        wr_ready;
    logic        log_clear = 1'b0;
    logic        rd_next = 1'b0;
    logic [15:0] rd_bcd;
    logic [4:0]  rd_index;
    logic        rd_sat;
    logic        bcd_valid;
    logic        busy;
    logic [5:0]  count;
    logic        full;
    logic        overflow;

    int check_count = 0;
    int pass_count  = 0;

    logic [31:0] model_q[$];
    int          model_rp  = 0;
    logic        model_ovf = 1'b0;

    typedef struct {
        logic [31:0] data;
        logic [15:0] bcd;
        logic        sat;
    } vec_t;

    always #5 clk = ~clk;

    cpu_result_logger #(.DEPTH(32), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .log_clear (log_clear),
        .rd_next   (rd_next),
        .rd_bcd    (rd_bcd),
        .rd_index  (rd_index),
        .rd_sat    (rd_sat),
        .bcd_valid (bcd_valid),
        .busy      (busy),
        .count     (count),
        .full      (full),
        .overflow  (overflow)
    );

    function automatic logic [15:0] to_bcd(logic [31:0] v);
        int unsigned c;
        c = (v > 32'd9999) ? 9999 : int'(v);
        return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic wv, input logic [31:0] wd, input logic clr, input logic rn);
        wr_valid  = wv;
        wr_data   = wd;
        log_clear = clr;
        rd_next   = rn;
        tick();
        wr_valid  = 1'b0;
        log_clear = 1'b0;
        rd_next   = 1'b0;
    endtask

    task automatic modelWrite(input logic [31:0] d);
        if (model_q.size() < 32) model_q.push_back(d);
        else model_ovf = 1'b1;
    endtask

    task automatic modelClear();
        model_q.delete();
        model_rp  = 0;
        model_ovf = 1'b0;
    endtask

    task automatic checkState();
        checkOutput("count", 32'(count), 32'(model_q.size()));
        checkOutput("full", 32'(full), 32'(model_q.size() == 32));
        checkOutput("wr_ready", 32'(wr_ready), 32'(model_q.size() != 32));
        checkOutput("overflow", 32'(overflow), 32'(model_ovf));
    endtask

    task automatic checkReset();
        checkOutput("rst_wr_ready", 32'(wr_ready), 32'd1);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_rd_bcd", 32'(rd_bcd), 32'd0);
        checkOutput("rst_rd_index", 32'(rd_index), 32'd0);
        checkOutput("rst_rd_sat", 32'(rd_sat), 32'd0);
        checkOutput("rst_bcd_valid", 32'(bcd_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        modelClear();
    endtask

    task automatic writeWord(input logic [31:0] d);
        applyStimulus(1'b1, d, 1'b0, 1'b0);
        modelWrite(d);
        checkState();
    endtask

    task automatic watchNoValid(input string name, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            if (bcd_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
            tick();
        end
        checkOutput(name, 32'(seen), 32'd0);
    endtask

    // Step once; caller guarantees the log is non-empty and the FSM idle.
    task automatic stepRead(input bit extra, input bit with_wr, input logic [31:0] wd,
                            output logic [15:0] got_bcd, output logic [4:0] got_idx, output logic got_sat);
        int exp_idx;
        int lat;
        exp_idx  = model_rp;
        model_rp = (model_rp + 1 >= model_q.size()) ? 0 : model_rp + 1;
        rd_next  = 1'b1;
        wr_valid = with_wr;
        wr_data  = wd;
        tick();
        rd_next  = 1'b0;
        wr_valid = 1'b0;
        if (with_wr) modelWrite(wd);
        checkOutput("busy_after_accept", 32'(busy), 32'd1);
        lat = 0;
        while (bcd_valid !== 1'b1 && lat < 40) begin
            if (extra && lat == 3) rd_next = 1'b1;
            tick();
            rd_next = 1'b0;
            lat++;
        end
        checkOutput("latency", 32'(lat), 32'd16);
        got_bcd = rd_bcd;
        got_idx = rd_index;
        got_sat = rd_sat;
        checkOutput("rd_index", 32'(rd_index), 32'(exp_idx));
        checkOutput("rd_bcd", 32'(rd_bcd), 32'(to_bcd(model_q[exp_idx])));
        checkOutput("rd_sat", 32'(rd_sat), 32'(model_q[exp_idx] > 32'd9999));
        tick();
        checkOutput("bcd_valid_single", 32'(bcd_valid), 32'd0);
        checkOutput("busy_back_idle", 32'(busy), 32'd0);
        if (with_wr) checkState();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        vecs[7];
        logic [15:0] gb;
        logic [4:0]  gi;
        logic        gs;
        logic [15:0] held_bcd;
        int          op;
        logic [31:0] d;

        vecs[0] = '{32'd0,          16'h0000, 1'b0};
        vecs[1] = '{32'd9,          16'h0009, 1'b0};
        vecs[2] = '{32'd9999,       16'h9999, 1'b0};
        vecs[3] = '{32'd10000,      16'h9999, 1'b1};
        vecs[4] = '{32'hFFFF_FFFF,  16'h9999, 1'b1};
        vecs[5] = '{32'd205,        16'h0205, 1'b0};
        vecs[6] = '{32'd1000,       16'h1000, 1'b0};

        tick();
        tick();
        reset = 1'b0;
        checkReset();

        $display("[TB] single entry 1234");
        writeWord(32'd1234);
        stepRead(1'b0, 1'b0, 32'd0, gb, gi, gs);
        checkOutput("t1_bcd", 32'(gb), 32'h1234);
        checkOutput("t1_idx", 32'(gi), 32'd0);
        checkState();

        $display("[TB] table vectors");
        doReset();
        foreach (vecs[i]) writeWord(vecs[i].data);
        foreach (vecs[i]) begin
            stepRead(1'b0, 1'b0, 32'd0, gb, gi, gs);
            checkOutput("vec_bcd", 32'(gb), 32'(vecs[i].bcd));
            checkOutput("vec_sat", 32'(gs), 32'(vecs[i].sat));
            checkOutput("vec_idx", 32'(gi), 32'(i));
        end

        $display("[TB] wrap and busy pulse");
        doReset();
        for (int i = 0; i < 3; i++) writeWord($urandom_range(0, 20000));
        for (int k = 0; k < 4; k++) begin
            stepRead(k == 1, 1'b0, 32'd0, gb, gi, gs);
            checkOutput("wrap_idx", 32'(gi), 32'(k % 3));
        end

        $display("[TB] fill and overflow");
        doReset();
        wr_valid = 1'b1;
        for (int i = 0; i < 33; i++) begin
            wr_data = 32'd1000 + 32'(i * 7);
            tick();
            modelWrite(wr_data);
            checkState();
        end
        wr_valid = 1'b0;
        for (int k = 0; k < 33; k++) begin
            stepRead(1'b0, 1'b0, 32'd0, gb, gi, gs);
            checkOutput("fill_idx", 32'(gi), 32'(k % 32));
        end
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        modelClear();
        checkState();

        $display("[TB] step on empty log");
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
        checkOutput("empty_busy", 32'(busy), 32'd0);
        watchNoValid("empty_no_valid", 20);

        $display("[TB] clear during conversion");
        writeWord(32'd500);
        writeWord(32'd600);
        stepRead(1'b0, 1'b0, 32'd0, gb, gi, gs);
        held_bcd = gb;
        checkOutput("pre_clear_bcd", 32'(held_bcd), 32'h0500);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) tick();
        applyStimulus(1'b1, 32'd5, 1'b1, 1'b0);
        modelClear();
        checkOutput("clr_busy", 32'(busy), 32'd0);
        checkState();
        watchNoValid("clr_no_valid", 20);
        checkOutput("clr_bcd_kept", 32'(rd_bcd), 32'h0500);
        checkOutput("clr_idx_kept", 32'(rd_index), 32'd0);
        writeWord(32'd42);
        writeWord(32'd43);
        stepRead(1'b0, 1'b0, 32'd0, gb, gi, gs);
        checkOutput("after_clr_bcd", 32'(gb), 32'h0042);

        $display("[TB] reset during conversion and write");
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) tick();
        reset    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 32'd77;
        tick();
        reset    = 1'b0;
        wr_valid = 1'b0;
        modelClear();
        checkReset();
        watchNoValid("rst_no_valid", 20);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 250; n++) begin
            op = $urandom_range(0, 19);
            d  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 12000)) : $urandom;
            if (op < 10) begin
                writeWord(d);
            end else if (op < 18) begin
                if (model_q.size() == 0) begin
                    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
                    checkOutput("rand_empty_busy", 32'(busy), 32'd0);
                end else begin
                    stepRead($urandom_range(0, 3) == 0, op >= 16, d, gb, gi, gs);
                end
            end else if (op == 18) begin
                applyStimulus(1'b1, d, 1'b1, 1'b0);
                modelClear();
                checkState();
            end else begin
                for (int k = 0; k < 12; k++) writeWord(32'($urandom_range(0, 99999)));
            end
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/cpu_result_logger.md
# cpu_result_logger

Captures CPU result words into a 32-entry on-chip log and serves them back, one entry per step request, as 4-digit packed BCD. The CPU writeback side pushes words through a valid/ready handshake. The 7-segment display side steps through logged entries with a single-cycle pulse. A sequential double-dabble converter produces the digits, so the display driver only multiplexes digits and looks up segments. This block is the write/producer end of the result-memory path that the display consumes.

## Interface
- DEPTH, 32, number of log entries (power of two; pointer width = log2(DEPTH)).
- DATA_W, 32, width of a logged CPU result word.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state on the clk edge where it is high.
- wr_valid  in  1  CPU has a result on wr_data.
- wr_data  in  DATA_W  result word, unsigned.
- wr_ready  out  1  log can accept a word (= !full).
- log_clear  in  1  one-cycle pulse; empties the log.
- rd_next  in  1  one-cycle step pulse (already debounced and edge-detected upstream).
- rd_bcd  out  16  packed BCD {thousands, hundreds, tens, ones} of the displayed entry.
- rd_index  out  5  index of the entry shown on rd_bcd.
- rd_sat  out  1  displayed entry exceeded 9999 and was clamped.
- bcd_valid  out  1  one-cycle pulse when rd_bcd/rd_index/rd_sat update.
- busy  out  1  conversion in progress.
- count  out  6  number of stored entries, 0..32.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky: a write was attempted while full.

## Operation
- Reset values: wr_ready 1, count 0, full 0, overflow 0, rd_bcd 0, rd_index 0, rd_sat 0, bcd_valid 0, busy 0. Internal write and read pointers are 0 and the FSM is IDLE. Memory contents are not cleared.
- Write: when wr_valid && wr_ready, store wr_data at mem[count] and increment count. No wrap on the write side: the log fills once.
- wr_valid while full: the word is dropped, count is unchanged, and overflow is set. overflow stays set until reset or log_clear.
- log_clear: sets count 0, full 0, overflow 0, and read pointer 0. It aborts any conversion, putting the FSM in IDLE with busy 0. It does not change rd_bcd, rd_index, or rd_sat. A write in the same cycle as log_clear is discarded.
- Read pointer rp: points at the next entry to display.
  - rd_next accepted in IDLE with count > 0 selects mem[rp].
  - On selection, rp advances to rp+1, or to 0 if rp+1 ≥ count.
  - The first step after reset or clear shows entry 0.
- rd_next is ignored when count == 0 or when the FSM is not IDLE. Ignored pulses are not queued.
- FSM states:
  - IDLE: on an accepted rd_next, go to LOAD.
  - LOAD: latch the entry. If the entry > 9999, the binary operand is 9999 and sat = 1; otherwise the operand is entry[13:0] and sat = 0. Clear the BCD accumulator and go to SHIFT with a shift counter of 14.
  - SHIFT: in each cycle, add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left by 1. After the 14th shift, go to DONE.
  - DONE: update rd_bcd, rd_index, and rd_sat; pulse bcd_valid; go to IDLE.
- busy = 1 in LOAD, SHIFT, and DONE.
- A simultaneous write and read are independent. The read uses the count value sampled on the accepting edge.

## Timing
- Write latency: data sampled on edge N appears in count after edge N. It is readable by an rd_next accepted on edge N+1 or later.
- wr_ready and full update on the same edge as count.
- Conversion: rd_next high before edge T is accepted on edge T, which enters LOAD.
  - LOAD occupies cycle T→T+1.
  - SHIFT runs for 14 cycles.
  - DONE is the cycle ending at edge T+16.
  - rd_bcd and rd_index change, and bcd_valid is high, in the cycle after edge T+16.
  - busy is high from after edge T through edge T+16.
  - The next rd_next can be accepted on edge T+17.
- Reset or log_clear during any state takes effect on that edge; the conversion is abandoned and no bcd_valid pulse occurs.

## Test plan
- Reset, write 1234, then rd_next: after 16 cycles, rd_bcd = 16'h1234, rd_index = 0, rd_sat = 0, single bcd_valid pulse, count = 1.
- Write 0, 9, 9999, 10000, and 32'hFFFFFFFF; step 5 times: rd_bcd = 0000, 0009, 9999, 9999, 9999; rd_sat = 0, 0, 0, 1, 1.
- Write 3 entries and step 4 times: rd_index = 0, 1, 2, 0 (wrap). An rd_next pulsed while busy causes no extra step.
- Write 33 words back-to-back with wr_valid held high: wr_ready drops after the 32nd, full = 1, count = 32, overflow = 1. The 33rd word is absent: stepping 32 times then once more shows entry 0.
- rd_next with count = 0 produces no busy and no bcd_valid. log_clear mid-SHIFT gives busy = 0 on the next cycle, no bcd_valid, count = 0, rd_bcd unchanged.
- Synchronous reset asserted mid-conversion and during a write: all outputs return to their reset values on that edge, and the write is not counted.
